// File: rtl/param_seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, unsigned or two's-complement.
// Operates on operand magnitudes and applies the result sign in FIN.
module param_seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [PW-1:0]     p_q, p_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  mag_a, mag_b;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    p_d      = p_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIN;
      end
      FIN: begin
        p_d     = sign_q ? (~acc_q + 1'b1) : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      p_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      p_q      <= p_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: tb/tb_param_seq_multiplier.sv
// Bench for param_seq_multiplier (WIDTH=4): vector table, random model checks,
// and hand sequences for busy-ignore, back-to-back and mid-op reset.
module tb_param_seq_multiplier;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a_i = '0;
  logic [W-1:0]   b_i = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [2*W-1:0] sb[$];

  typedef struct {
    logic           sm;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_p;
  } vec_t;

  param_seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a_i), .b(b_i), .busy(busy), .done(done), .p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse consumes the oldest expected product.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("p_result", {24'd0, p}, {24'd0, sb.pop_front()});
    end
  end

  function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [15:0] sp;
    logic [15:0] up;
    sp = 16'($signed(a)) * 16'($signed(b));
    up = {12'd0, a} * {12'd0, b};
    return sm ? sp[2*W-1:0] : up[2*W-1:0];
  endfunction

  task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_p, input bit push);
    signed_mode = sm; a_i = a; b_i = b; start = 1'b1;
    if (push) sb.push_back(exp_p);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
  endtask

  initial begin
    vec_t vt[12];
    int lat;
    logic [2*W-1:0] hold;
    vt[0]  = '{1'b0, 4'd2, 4'd3, 8'h06};
    vt[1]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
    vt[2]  = '{1'b1, 4'hD, 4'h5, 8'hF1};
    vt[3]  = '{1'b1, 4'h8, 4'h8, 8'h40};
    vt[4]  = '{1'b1, 4'h8, 4'h1, 8'hF8};
    vt[5]  = '{1'b0, 4'h0, 4'h9, 8'h00};
    vt[6]  = '{1'b1, 4'h0, 4'hF, 8'h00};
    vt[7]  = '{1'b1, 4'hF, 4'hF, 8'h01};
    vt[8]  = '{1'b1, 4'h7, 4'h8, 8'hC8};
    vt[9]  = '{1'b0, 4'h8, 4'h8, 8'h40};
    vt[10] = '{1'b1, 4'hF, 4'h1, 8'hFF};
    vt[11] = '{1'b0, 4'hF, 4'h1, 8'h0F};

    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_p", {24'd0, p}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      issue(vt[i].sm, vt[i].a, vt[i].b, vt[i].exp_p, 1'b1);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(lat);
      check("latency", lat, W + 2);
      hold = p;
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check("p_hold", {24'd0, p}, {24'd0, hold});
    end

    for (int i = 0; i < 20; i++) begin
      logic sm; logic [W-1:0] ra, rb;
      sm = 1'($urandom_range(0, 1)); ra = W'($urandom); rb = W'($urandom);
      issue(sm, ra, rb, model(sm, ra, rb), 1'b1);
      wait_done(lat);
      check("rand_latency", lat, W + 2);
    end

    // start while busy is ignored and input changes do not disturb the op
    @(posedge clk); #1;
    issue(1'b0, 4'd3, 4'd4, 8'h0C, 1'b1);
    @(posedge clk); #1;
    issue(1'b0, 4'd7, 4'd7, 8'h31, 1'b0);
    signed_mode = 1'b1; a_i = 4'h9; b_i = 4'hA;
    wait_done(lat);
    check("busy_ignore_latency", lat, W);
    repeat (8) @(negedge clk);

    // back-to-back: start raised in the done cycle
    @(posedge clk); #1;
    issue(1'b0, 4'd5, 4'd6, 8'h1E, 1'b1);
    wait_done(lat);
    check("b2b_first_latency", lat, W + 2);
    issue(1'b1, 4'hE, 4'd3, 8'hFA, 1'b1);
    wait_done(lat);
    check("b2b_second_latency", lat, W + 2);

    // async reset two cycles into CALC
    @(posedge clk); #1;
    issue(1'b0, 4'hF, 4'hF, 8'hE1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_p", {24'd0, p}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_p_stays", {24'd0, p}, 32'd0);
    issue(1'b1, 4'h3, 4'hC, 8'hF4, 1'b1);
    wait_done(lat);
    check("post_reset_latency", lat, W + 2);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    check("done_count", n_done, 32'd36);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 2..32.
REQ-002 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1: reset, asynchronous, active-low.
REQ-004 Port start  input  1: request to begin a multiply; sampled on the rising edge of clk.
REQ-005 Port signed_mode  input  1: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port a  input  WIDTH: multiplicand; sampled with start.
REQ-007 Port b  input  WIDTH: multiplier; sampled with start.
REQ-008 Port busy  output  1: high while an operation is in progress.
REQ-009 Port done  output  1: one-cycle pulse marking a new valid p.
REQ-010 Port p  output  2*WIDTH: product; two's-complement when signed_mode was 1.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and FIN; all outputs are registered.
REQ-012 Acceptance: start=1 in IDLE at an edge latches a, b and signed_mode, clears the accumulator and iteration counter, and enters CALC.
REQ-013 Signed mode, at acceptance: store operand magnitudes (unsigned, WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1)) and result sign = a[MSB] XOR b[MSB].
REQ-014 Unsigned mode, at acceptance: store operands unchanged; result sign = 0.
REQ-015 CALC: one radix-2 shift-add iteration per edge (add shifted multiplicand when the current multiplier bit is 1); 2*WIDTH-bit accumulator, no truncation.
REQ-016 After exactly WIDTH iterations in CALC, the FSM SHALL enter FIN.
REQ-017 FIN, next edge: p <= sign ? two's-complement negation of the accumulator : accumulator; done <= 1; enter IDLE.
REQ-018 Latency: done SHALL be high in the cycle after edge N+WIDTH+1, where N is the accepting edge; p updates on that same edge.
REQ-019 done SHALL be high for exactly one cycle per accepted operation.
REQ-020 busy SHALL be 1 in CALC and FIN, and 0 in IDLE.
REQ-021 p SHALL hold its value until the next FIN completes.
REQ-022 start while busy=1 SHALL be ignored; in-flight latched operands SHALL not be affected by input changes.
REQ-023 start=1 in the cycle done=1 (IDLE) SHALL be accepted: back-to-back throughput is one result per WIDTH+2 cycles.
REQ-024 A zero product SHALL yield p = 0 in both modes.
REQ-025 Signed -2^(WIDTH-1) * -2^(WIDTH-1) SHALL yield +2^(2*WIDTH-2) exactly.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, force: state IDLE; busy=0; done=0; p=0; accumulator, operands, counter and sign cleared.
REQ-027 Reset asserted mid-operation SHALL abandon it: no done pulse, p=0.
REQ-028 The first start after rst returns high SHALL be accepted at the first rising edge that samples start=1.

Verification (WIDTH=4)
REQ-029 Unsigned a=2, b=3, start one cycle -> busy next cycle; done pulse 5 cycles after acceptance; p=8'h06.
REQ-030 Unsigned a=15, b=15 -> p=8'hE1 (225); signed_mode=1 a=4'hD (-3), b=5 -> p=8'hF1 (-15).
REQ-031 Signed a=4'h8, b=4'h8 -> p=8'h40; signed a=4'h8, b=1 -> p=8'hF8.
REQ-032 Start op 3*4; pulse start again with a=7, b=7 while busy; change inputs mid-op -> single done, p=8'h0C.
REQ-033 Start asserted on the done cycle with new operands -> second operation accepted without gap; second done exactly 6 cycles later.
REQ-034 rst=0 asynchronously two cycles into CALC -> busy, done, p=0 immediately; no done afterwards; next start completes normally.
